i2s_rx: RTL and testbench
=========================

// Module: i2s_rx
// PURPOSE
//  Slave-mode I2S receiver, the counterpart of the AudVid I2S transmitter. Takes SCK/WS/SD
//  from an external ADC or codec and deserialises each stereo frame into a {Left,Right} word.
//  Delivers words on a valid/ready stream to the audio path (loopback, capture, SD write-back).
//  All logic runs in the MasterCLK domain; I2S pins are synchronised and oversampled.
// PARAMETERS
//  SAMPLE_WIDTH  16  bits per channel kept, MSB-first; extra bits per channel are discarded
//  FIFO_DEPTH    4   output FIFO entries; power of 2, >=2; used only with I2S_RX_FIFO_EN
// PORTS
//  MasterCLK    in   1               the block's only clock
//  Reset        in   1               asynchronous, active-low
//  Enable       in   1               0: frame tracker idles in HUNT, no words produced
//  I2S_CLK      in   1               external bit clock SCK; async; MasterCLK >= 4x SCK
//  I2S_WS       in   1               word select; 0 = left, 1 = right
//  I2S_DATA     in   1               serial data
//  SampleData   out  2*SAMPLE_WIDTH  {Left,Right}; Left in the MSBs
//  SampleValid  out  1               word available
//  SampleReady  in   1               consumer accepts; transfer = Valid & Ready on a MasterCLK edge
//  Overrun      out  1               sticky: a complete frame was dropped
//  FrameError   out  1               sticky: a channel ended with fewer than SAMPLE_WIDTH bits
//  ClearFlags   in   1               1-cycle pulse; clears Overrun and FrameError
// BEHAVIOUR
//  Reset: SampleData=0, SampleValid=0, Overrun=0, FrameError=0, state=HUNT, FIFO empty.
//  Reset asserted mid-frame discards the partial frame and all buffered words.
//  Input path: 2-FF synchroniser on SCK, WS and SD; SCK rise is detected on the synchronised
//   edge. Each rise k samples D_k and W_k. The SCK-rise-to-internal-capture latency is 3 MasterCLK.
//  Framing (Philips I2S): if W_k != W_(k-1), a channel starts at rise k+1. Bits D_(k+1)..
//   D_(k+SAMPLE_WIDTH) form that channel's word, MSB first. Bit counter saturates; later bits ignored.
//  Short channel: if WS toggles before SAMPLE_WIDTH bits arrive, the unfilled LSBs are 0.
//   FrameError is set, and the word is still used.
//  FSM states: HUNT -> (first WS 1->0) LEFT -> (WS 0->1) RIGHT -> (WS 1->0) LEFT ...
//   HUNT discards all bits. Enable=0 forces HUNT at the next cycle, and the partial frame is lost.
//  Left word completes into a hold register. The frame completes when the Right word reaches
//   SAMPLE_WIDTH bits, or when a short channel ends at the WS toggle.
//   Push happens the MasterCLK cycle after the completing capture.
//  Push with a buffer slot free, or with a pop in the same cycle: the word is accepted.
//   Otherwise the new word is dropped and Overrun=1. Buffered data is never overwritten.
//  SampleData/SampleValid are registered and change only on push or pop. Data is stable while
//   Valid=1 and Ready=0.
//  ClearFlags on the same cycle as a new error event: the flag is set (the event wins).
// CONFIGURATION
//  I2S_RX_FIFO_EN defined: FIFO_DEPTH-entry FIFO.
//   - SampleData shows the head entry.
//   - Full is detected with a pointer-wrap bit. Empty gives Valid=0.
//   - Simultaneous push and pop when full is allowed; the count does not change.
//  I2S_RX_FIFO_EN undefined: single output register, equivalent to depth 1.
//   - Valid&Ready together with a push loads the new word and keeps Valid=1.
//   - Push while Valid&!Ready drops the word and sets Overrun.
// STRUCTURE
//  audvid_pkg:
//   - I2S_SAMPLE_WIDTH default
//   - rx_state_t enum {HUNT,LEFT,RIGHT}
//   - CH_LEFT/CH_RIGHT WS constants
//  Sub-module i2s_rx_sync: 2-FF synchroniser plus SCK rising-edge detect for the 3 pins.
//  FIFO: inline storage array with rd/wr pointers. No separate module.
// TESTING
//  1. Reset, then 16-bit frames L=16'hA55A, R=16'h0F0F at SCK=MasterCLK/8, Ready=1
//     -> SampleData=32'hA55A0F0F, one Valid pulse per frame.
//  2. Start with WS=1 mid-right-channel -> no word until the first WS fall. The first word is
//     the next full L/R pair.
//  3. 24-bit ADC frames, L=24'h123456, R=24'hFEDCBA -> SampleData=32'h1234FEDC, FrameError=0.
//  4. Frame with only 8 bits per channel, L=8'hC3, R=8'h81 -> SampleData=32'hC3008100,
//     FrameError=1 until ClearFlags.
//  5. Ready=0 for 6 frames -> without the macro, word 1 is held and Overrun=1 on frame 2.
//     With the macro, words 1-4 are held, Overrun=1 on frame 5, and the pop order is 1,2,3,4.
//  6. Reset pulse and Enable=0 each mid-right-channel -> Valid=0, and the partial frame is
//     never emitted. Resync at the next WS fall.

Source files
------------

// File: rtl/audvid_pkg.sv
// Shared definitions for the AudVid I2S receive path.
package audvid_pkg;

  localparam int I2S_SAMPLE_WIDTH = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// Two-flop synchronisers for SCK, WS and SD plus SCK rising-edge detect.
// WS and SD go through the same depth as SCK, so ws_o/sd_o line up with sck_rise_o.
module i2s_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic sck_rise_o,
  output logic ws_o,
  output logic sd_o
);

  logic [2:0] sck_q, sck_d;
  logic [1:0] ws_q, ws_d;
  logic [1:0] sd_q, sd_d;

  // Shift each pin into its synchroniser chain; SCK keeps one extra stage for edge detect.
  always_comb begin
    sck_d = {sck_q[1:0], sck_i};
    ws_d  = {ws_q[0], ws_i};
    sd_d  = {sd_q[0], sd_i};
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= '0;
      ws_q  <= '0;
      sd_q  <= '0;
    end else begin
      sck_q <= sck_d;
      ws_q  <= ws_d;
      sd_q  <= sd_d;
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign ws_o       = ws_q[1];
  assign sd_o       = sd_q[1];

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode Philips I2S receiver: deserialises {Left,Right} frames onto a
// valid/ready stream. Define I2S_RX_FIFO_EN for a FIFO_DEPTH-entry output
// FIFO; otherwise a single output register is used.
module i2s_rx
  import audvid_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      MasterCLK,
  input  logic                      Reset,
  input  logic                      Enable,
  input  logic                      I2S_CLK,
  input  logic                      I2S_WS,
  input  logic                      I2S_DATA,
  output logic [2*SAMPLE_WIDTH-1:0] SampleData,
  output logic                      SampleValid,
  input  logic                      SampleReady,
  output logic                      Overrun,
  output logic                      FrameError,
  input  logic                      ClearFlags
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int DW = 2 * SAMPLE_WIDTH;
  localparam logic [CW-1:0] SW_CNT = CW'(SAMPLE_WIDTH);

  logic sck_rise, ws_s, sd_s;

  i2s_rx_sync u_sync (
    .clk        (MasterCLK),
    .rst_n      (Reset),
    .sck_i      (I2S_CLK),
    .ws_i       (I2S_WS),
    .sd_i       (I2S_DATA),
    .sck_rise_o (sck_rise),
    .ws_o       (ws_s),
    .sd_o       (sd_s)
  );

  rx_state_t               state_q, state_d;
  logic                    ws_prev_q, ws_prev_d;
  logic [SAMPLE_WIDTH-1:0] sh_q, sh_d, sh_nx, word;
  logic [CW-1:0]           cnt_q, cnt_d, cnt_nx;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic                    push_q, push_d;
  logic [DW-1:0]           push_data_q, push_data_d;
  logic                    toggle, done, short_evt;
  logic [DW-1:0]           data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d, ovr_q, ovr_d, ovr_evt;
  logic                    pop, accept;

  // Frame tracker: shifts bits into the current channel and completes words.
  // The bit at a WS-toggle rise is the last bit of the channel that is ending.
  always_comb begin
    state_d     = state_q;
    ws_prev_d   = ws_prev_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    toggle      = 1'b0;
    done        = 1'b0;
    short_evt   = 1'b0;
    sh_nx       = sh_q;
    cnt_nx      = cnt_q;
    word        = '0;
    if (sck_rise) begin
      toggle    = (ws_s != ws_prev_q);
      ws_prev_d = ws_s;
      if (Enable && state_q != HUNT) begin
        if (cnt_q < SW_CNT) begin
          sh_nx  = {sh_q[SAMPLE_WIDTH-2:0], sd_s};
          cnt_nx = cnt_q + CW'(1);
        end
        // Left-justify a short word so the missing LSBs read as zero.
        word      = sh_nx << (SW_CNT - cnt_nx);
        short_evt = toggle && (cnt_nx < SW_CNT);
        done      = short_evt || ((cnt_q < SW_CNT) && (cnt_nx == SW_CNT));
        if (done) begin
          if (state_q == LEFT) begin
            hold_d = word;
          end else begin
            push_d      = 1'b1;
            push_data_d = {hold_q, word};
          end
        end
        sh_d  = sh_nx;
        cnt_d = cnt_nx;
      end
      if (toggle) begin
        sh_d  = '0;
        cnt_d = '0;
        if (ws_s == CH_LEFT) begin
          state_d = LEFT;
        end else if (state_q != HUNT) begin
          state_d = RIGHT;
        end
      end
    end
    if (!Enable) begin
      state_d = HUNT;
      sh_d    = '0;
      cnt_d   = '0;
    end
  end

`ifdef I2S_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          full;

  // FIFO control: the extra pointer bit separates full from empty; a pop frees a slot for a same-cycle push.
  always_comb begin
    mem_d    = mem_q;
    pop      = valid_q & SampleReady;
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    accept   = push_q & (~full | pop);
    if (accept) mem_d[wr_ptr_q[AW-1:0]] = push_data_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, accept};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    valid_d  = (wr_ptr_d != rd_ptr_d);
    data_d   = data_q;
    if ((accept || pop) && valid_d) data_d = mem_d[rd_ptr_d[AW-1:0]];
    ovr_evt  = push_q & ~accept;
  end

  // FIFO pointers; emptied on reset.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge MasterCLK) begin
    mem_q <= mem_d;
  end
`else
  // Single output register: a push is taken only if the register is empty or being popped.
  always_comb begin
    pop     = valid_q & SampleReady;
    accept  = push_q & (~valid_q | pop);
    valid_d = accept | (valid_q & ~pop);
    data_d  = accept ? push_data_q : data_q;
    ovr_evt = push_q & ~accept;
  end
`endif

  // Sticky flags: a new event wins over a same-cycle clear.
  assign ferr_d = short_evt | (ferr_q & ~ClearFlags);
  assign ovr_d  = ovr_evt | (ovr_q & ~ClearFlags);

  // Tracker, push stage, output register and flag state.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= HUNT;
      ws_prev_q   <= CH_LEFT;
      sh_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_prev_q   <= ws_prev_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign SampleData  = data_q;
  assign SampleValid = valid_q;
  assign Overrun     = ovr_q;
  assign FrameError  = ferr_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx (SAMPLE_WIDTH=16). Build with +define+I2S_RX_FIFO_EN
// to exercise the FIFO variant; the expected buffer depth follows the same macro.
module tb_i2s_rx;

  localparam int SW = 16;
`ifdef I2S_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        MasterCLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic        I2S_CLK = 1'b0;
  logic        I2S_WS = 1'b1;
  logic        I2S_DATA = 1'b0;
  logic        SampleReady = 1'b1;
  logic        ClearFlags = 1'b0;
  logic [31:0] SampleData;
  logic        SampleValid, Overrun, FrameError;

  always #5 MasterCLK = ~MasterCLK;

  i2s_rx dut (
    .MasterCLK   (MasterCLK),
    .Reset       (Reset),
    .Enable      (Enable),
    .I2S_CLK     (I2S_CLK),
    .I2S_WS      (I2S_WS),
    .I2S_DATA    (I2S_DATA),
    .SampleData  (SampleData),
    .SampleValid (SampleValid),
    .SampleReady (SampleReady),
    .Overrun     (Overrun),
    .FrameError  (FrameError),
    .ClearFlags  (ClearFlags)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_xfer = 0;
  logic [31:0] exp_q[$];
  bit          rand_ready = 1'b0;
  bit          stall = 1'b0;
  logic [31:0] stall_data = '0;

  typedef struct {
    int          nl;
    logic [31:0] l;
    int          nr;
    logic [31:0] r;
    logic [31:0] exp_data;
    logic        exp_ferr;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: channel word is the first 16 bits sent (MSB first), zero-padded if shorter.
  function automatic logic [15:0] ch_word(input logic [31:0] w, input int n);
    logic [31:0] t;
    if (n >= SW) t = w >> (n - SW);
    else         t = w << (SW - n);
    return t[15:0];
  endfunction

  function automatic logic [31:0] frame_word(input logic [31:0] l, input int nl,
                                             input logic [31:0] r, input int nr);
    return {ch_word(l, nl), ch_word(r, nr)};
  endfunction

  // One SCK period of 8 MasterCLK; WS/SD change while SCK is low.
  task automatic send_bit(input logic ws, input logic d);
    I2S_CLK = 1'b0; I2S_WS = ws; I2S_DATA = d;
    repeat (4) @(negedge MasterCLK);
    I2S_CLK = 1'b1;
    repeat (4) @(negedge MasterCLK);
  endtask

  // Philips framing: the last bit of a channel is sent with WS already toggled.
  task automatic send_channel(input logic ws, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit((i == n - 1) ? ~ws : ws, w[n-1-i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
    send_channel(1'b0, l, nl);
    send_channel(1'b1, r, nr);
  endtask

  task automatic idle(input int n);
    I2S_CLK = 1'b0;
    repeat (n) @(negedge MasterCLK);
  endtask

  task automatic pulse_clear();
    ClearFlags = 1'b1;
    @(negedge MasterCLK);
    ClearFlags = 1'b0;
  endtask

  // Output monitor: every transfer must match the next expected word in order.
  always @(negedge MasterCLK) begin
    #1;
    if (!Reset) begin
      stall = 1'b0;
    end else begin
      if (stall && SampleValid) check("hold_stable", SampleData, stall_data);
      if (SampleValid && SampleReady) begin
        n_xfer++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word_unexpected: got %h, expected no word", SampleData);
        end else begin
          logic [31:0] e;
          n_chk--;
          e = exp_q.pop_front();
          check("word", SampleData, e);
        end
      end
      stall      = SampleValid && !SampleReady;
      stall_data = SampleData;
    end
  end

  always @(negedge MasterCLK) begin
    if (rand_ready) SampleReady = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1);
  end

  initial begin
    int x0;
    vecs[0] = '{16, 32'hA55A,   16, 32'h0F0F,   32'hA55A0F0F, 1'b0};
    vecs[1] = '{24, 32'h123456, 24, 32'hFEDCBA, 32'h1234FEDC, 1'b0};
    vecs[2] = '{8,  32'hC3,     8,  32'h81,     32'hC3008100, 1'b1};
    vecs[3] = '{16, 32'hFFFF,   16, 32'h0001,   32'hFFFF0001, 1'b0};
    vecs[4] = '{16, 32'h8001,   12, 32'hABC,    32'h8001ABC0, 1'b1};
    vecs[5] = '{17, 32'h12345,  16, 32'h0000,   32'h91A20000, 1'b0};

    repeat (3) @(negedge MasterCLK);
    check("rst_data", SampleData, 32'h0);
    check("rst_valid", SampleValid, 1'b0);
    check("rst_overrun", Overrun, 1'b0);
    check("rst_ferr", FrameError, 1'b0);
    Reset = 1'b1; Enable = 1'b1;
    idle(2);

    // Start mid-right-channel: nothing until the first WS fall.
    x0 = n_xfer;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    send_bit(1'b0, 1'b1);
    idle(4);
    check("hunt_no_word", n_xfer - x0, 0);

    // Directed frame table.
    for (int v = 0; v < 6; v++) begin
      pulse_clear();
      check("vec_ferr_clear", FrameError, 1'b0);
      exp_q.push_back(vecs[v].exp_data);
      x0 = n_xfer;
      send_frame(vecs[v].l, vecs[v].nl, vecs[v].r, vecs[v].nr);
      idle(6);
      check("vec_one_pulse", n_xfer - x0, 1);
      check("vec_ferr", FrameError, vecs[v].exp_ferr);
      check("vec_queue_empty", exp_q.size(), 0);
    end

    // Capture-to-Valid latency: capture 3 MasterCLK after the SCK rise, push one later.
    pulse_clear();
    exp_q.push_back(32'h5AA53C3C);
    send_channel(1'b0, 32'h5AA5, 16);
    for (int i = 0; i < 15; i++) send_bit(1'b1, 1'((32'h3C3C >> (15 - i)) & 1));
    I2S_CLK = 1'b0; I2S_WS = 1'b0; I2S_DATA = 1'b0;
    repeat (4) @(negedge MasterCLK);
    I2S_CLK = 1'b1;
    repeat (3) @(negedge MasterCLK);
    check("latency_before", SampleValid, 1'b0);
    @(negedge MasterCLK);
    check("latency_at", SampleValid, 1'b1);
    idle(4);

    // Back-pressure: DEPTH words held, the rest dropped with Overrun.
    SampleReady = 1'b0;
    pulse_clear();
    check("ovr_clear", Overrun, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = {16'h1100 + 16'(i), 16'h2200 + 16'(i)};
      if (i < DEPTH) exp_q.push_back(w);
      send_frame({16'h0, w[31:16]}, 16, {16'h0, w[15:0]}, 16);
      idle(3);
      check("ovr_flag", Overrun, (i >= DEPTH));
      check("ovr_valid", SampleValid, 1'b1);
      check("ovr_head", SampleData, 32'h11002200);
    end
    x0 = n_xfer;
    SampleReady = 1'b1;
    idle(DEPTH + 4);
    check("ovr_drain_count", n_xfer - x0, DEPTH);
    check("ovr_drain_queue", exp_q.size(), 0);
    check("ovr_sticky", Overrun, 1'b1);
    pulse_clear();
    check("ovr_cleared", Overrun, 1'b0);

    // Reset mid-right-channel with a buffered word: everything is discarded.
    SampleReady = 1'b0;
    send_frame(32'hDEAD, 16, 32'hBEEF, 16);
    idle(3);
    check("pre_rst_valid", SampleValid, 1'b1);
    send_channel(1'b0, 32'h1234, 16);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
    Reset = 1'b0;
    @(negedge MasterCLK);
    check("mid_rst_valid", SampleValid, 1'b0);
    check("mid_rst_data", SampleData, 32'h0);
    Reset = 1'b1;
    SampleReady = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    send_bit(1'b0, 1'b0);
    check("post_rst_no_partial", n_xfer - x0, 0);
    exp_q.push_back(32'h43218765);
    send_frame(32'h4321, 16, 32'h8765, 16);
    idle(4);
    check("post_rst_one", n_xfer - x0, 1);
    check("post_rst_queue", exp_q.size(), 0);

    // Enable=0 across a whole frame, then resync needs a fresh WS fall.
    Enable = 1'b0;
    x0 = n_xfer;
    send_frame(32'hAAAA, 16, 32'h5555, 16);
    idle(4);
    check("dis_no_word", n_xfer - x0, 0);
    Enable = 1'b1;
    send_frame(32'h1111, 16, 32'h2222, 16);
    idle(4);
    check("dis_resync_lost", n_xfer - x0, 0);
    exp_q.push_back(32'h77778888);
    send_frame(32'h7777, 16, 32'h8888, 16);
    idle(4);
    check("dis_resync_one", n_xfer - x0, 1);

    // Enable drop mid-right-channel.
    x0 = n_xfer;
    send_channel(1'b0, 32'h0BAD, 16);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    Enable = 1'b0;
    idle(3);
    check("en_drop_valid", SampleValid, 1'b0);
    Enable = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    exp_q.push_back(32'hCAFEF00D);
    send_frame(32'hCAFE, 16, 32'hF00D, 16);
    idle(4);
    check("en_drop_one", n_xfer - x0, 1);
    check("en_drop_queue", exp_q.size(), 0);

    // Randomized frames with random lengths and random Ready against the reference model.
    rand_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      int nl, nr;
      logic [31:0] l, r;
      nl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 24)) : 16;
      nr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 24)) : 16;
      l = $urandom & ((32'h1 << nl) - 32'h1);
      r = $urandom & ((32'h1 << nr) - 32'h1);
      pulse_clear();
      exp_q.push_back(frame_word(l, nl, r, nr));
      send_frame(l, nl, r, nr);
      idle(4);
      check("rand_ferr", FrameError, (nl < SW) || (nr < SW));
    end
    rand_ready = 1'b0;
    @(negedge MasterCLK);
    SampleReady = 1'b1;
    idle(6);
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_no_overrun", Overrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
